// File: rtl/tracesys_capture_demux.sv
// tracesys_capture_demux
//   Splits one Avalon-ST packet stream back into per-source streams. The
//   channel on the SOP beat picks the output port for the whole packet.
//   Packets whose channel has no port are swallowed and counted. Each
//   output has a one-entry registered buffer, so data reaches an output
//   one cycle after it is accepted.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   in_*                input stream (valid/ready, data, SOP/EOP, empty, channel)
//   out_*               NUM_OUTPUTS output streams, port i in slice i of each bus
//   drop_count          dropped-packet count, saturates at 16'hFFFF
//   sop_error           single-cycle pulse for each framing-error beat
//
// state | meaning
// IDLE  | between packets, waiting for an SOP beat
// ROUTE | inside a packet that goes to the latched port
// DROP  | inside a packet whose channel has no port; beats are discarded

module tracesys_capture_demux #(
    parameter int DATA_WIDTH    = 32,
    parameter int EMPTY_WIDTH   = 2,
    parameter int CHANNEL_WIDTH = 2,
    parameter int NUM_OUTPUTS   = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_startofpacket,
    input  logic                               in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]             in_empty,
    input  logic [CHANNEL_WIDTH-1:0]           in_channel,
    output logic [NUM_OUTPUTS-1:0]             out_valid,
    input  logic [NUM_OUTPUTS-1:0]             out_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_OUTPUTS-1:0]             out_startofpacket,
    output logic [NUM_OUTPUTS-1:0]             out_endofpacket,
    output logic [NUM_OUTPUTS*EMPTY_WIDTH-1:0] out_empty,
    output logic [15:0]                        drop_count,
    output logic                               sop_error
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    // One extra bit so NUM_OUTPUTS == 2**CHANNEL_WIDTH still compares correctly.
    localparam logic [CHANNEL_WIDTH:0] NUM_OUT_W = (CHANNEL_WIDTH + 1)'(NUM_OUTPUTS);

    state_t                   state, state_nxt;
    logic [CHANNEL_WIDTH-1:0] ch_q, ch_nxt, tgt;
    logic                     ch_ok, routed, accept, serr_nxt, drop_inc;
    logic [NUM_OUTPUTS-1:0]   sel, load;

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_q;
        in_ready  = 1'b1;
        serr_nxt  = 1'b0;
        drop_inc  = 1'b0;
        load      = '0;
        sel       = '0;

        tgt    = in_startofpacket ? in_channel : ch_q;
        ch_ok  = ({1'b0, in_channel} < NUM_OUT_W);
        routed = in_startofpacket ? ch_ok : (state == ROUTE);

        // One-hot port select; an out-of-range tgt simply selects nothing.
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            sel[i] = (tgt == CHANNEL_WIDTH'(i));
        end

        // Routed beats wait only on their own port; discarded beats never wait.
        if (routed) begin
            in_ready = |(sel & (out_ready | ~out_valid));
        end

        accept = in_valid && in_ready;

        if (accept) begin
            if (routed) begin
                load = sel;
            end
            if (in_startofpacket) begin
                // An SOP inside a packet abandons that packet and starts a new one.
                serr_nxt = (state != IDLE);
                if (ch_ok) begin
                    ch_nxt = in_channel;
                end
                if (in_endofpacket) begin
                    state_nxt = IDLE;
                    drop_inc  = !ch_ok;
                end else begin
                    state_nxt = ch_ok ? ROUTE : DROP;
                end
            end else begin
                case (state)
                    IDLE: serr_nxt = 1'b1;
                    ROUTE, DROP: begin
                        if (in_endofpacket) begin
                            state_nxt = IDLE;
                            drop_inc  = (state == DROP);
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ch_q       <= '0;
            sop_error  <= 1'b0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            ch_q      <= ch_nxt;
            sop_error <= serr_nxt;
            if (drop_inc && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Output buffers: a load wins over a drain, which gives full throughput
    // when a full port is being read in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= '0;
            out_data          <= '0;
            out_startofpacket <= '0;
            out_endofpacket   <= '0;
            out_empty         <= '0;
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (load[i]) begin
                    out_valid[i]                          <= 1'b1;
                    out_data[i*DATA_WIDTH +: DATA_WIDTH]   <= in_data;
                    out_startofpacket[i]                  <= in_startofpacket;
                    out_endofpacket[i]                    <= in_endofpacket;
                    out_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH] <= in_empty;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tracesys_capture_demux.sv
module tb_tracesys_capture_demux;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 2;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_startofpacket = 1'b0;
    logic            in_endofpacket = 1'b0;
    logic [EW-1:0]   in_empty = '0;
    logic [CW-1:0]   in_channel = '0;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = '1;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_startofpacket;
    logic [N-1:0]    out_endofpacket;
    logic [N*EW-1:0] out_empty;
    logic [15:0]     drop_count;
    logic            sop_error;

    tracesys_capture_demux #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .NUM_OUTPUTS(N)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_empty(in_empty), .in_channel(in_channel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_empty(out_empty), .drop_count(drop_count), .sop_error(sop_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, sop, eop;
        logic [1:0]  ch;
        logic [31:0] d;
        logic [1:0]  emp;
        logic [2:0]  ordy;
        logic        e_irdy;
        logic [2:0]  e_ov;
        int          port;
        logic [31:0] e_d;
        logic        e_sop, e_eop;
        logic [1:0]  e_emp;
        logic        e_serr;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, sop, eop, input logic [1:0] ch, input logic [31:0] d,
                       input logic [1:0] emp, input logic [2:0] ordy, input logic irdy,
                       input logic [2:0] ov, input int port, input logic [31:0] pd,
                       input logic psop, peop, input logic [1:0] pemp, input logic serr,
                       input logic [15:0] drop);
        vec_t t;
        t.v = v; t.sop = sop; t.eop = eop; t.ch = ch; t.d = d; t.emp = emp; t.ordy = ordy;
        t.e_irdy = irdy; t.e_ov = ov; t.port = port; t.e_d = pd; t.e_sop = psop;
        t.e_eop = peop; t.e_emp = pemp; t.e_serr = serr; t.e_drop = drop;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, sop, eop, input logic [1:0] ch, input logic [31:0] d,
                         input logic [1:0] emp, input logic [2:0] ordy);
        in_valid = v; in_startofpacket = sop; in_endofpacket = eop;
        in_channel = ch; in_data = d; in_empty = emp; out_ready = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3'b111);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: ch1 three-beat packet
        add(1,1,0,1,32'h11,0,7, 1,3'b010, 1,32'h11,1,0,0, 0,0);
        add(1,0,0,1,32'h22,0,7, 1,3'b010, 1,32'h22,0,0,0, 0,0);
        add(1,0,1,1,32'h33,2,7, 1,3'b010, 1,32'h33,0,1,2, 0,0);
        add(0,0,0,0,32'h0 ,0,7, 1,3'b000,-1,0,0,0,0, 0,0);
        // 2: port0 stalled; ch2 packet waits behind it
        add(1,1,0,0,32'hA0,0,6, 1,3'b001, 0,32'hA0,1,0,0, 0,0);
        add(1,0,0,0,32'hA1,0,6, 0,3'b001, 0,32'hA0,1,0,0, 0,0);
        add(1,0,0,0,32'hA1,0,6, 0,3'b001, 0,32'hA0,1,0,0, 0,0);
        add(1,0,0,0,32'hA1,0,6, 0,3'b001, 0,32'hA0,1,0,0, 0,0);
        add(1,0,0,0,32'hA1,0,7, 1,3'b001, 0,32'hA1,0,0,0, 0,0);
        add(1,0,1,0,32'hA2,1,6, 0,3'b001, 0,32'hA1,0,0,0, 0,0);
        add(1,0,1,0,32'hA2,1,6, 0,3'b001, 0,32'hA1,0,0,0, 0,0);
        add(1,0,1,0,32'hA2,1,7, 1,3'b001, 0,32'hA2,0,1,1, 0,0);
        add(1,1,1,2,32'hB0,3,7, 1,3'b100, 2,32'hB0,1,1,3, 0,0);
        add(0,0,0,0,32'h0 ,0,7, 1,3'b000,-1,0,0,0,0, 0,0);
        // 3: dropped packets, no out_ready at all
        add(1,1,0,3,32'hC0,0,0, 1,3'b000,-1,0,0,0,0, 0,0);
        add(1,0,0,3,32'hC1,0,0, 1,3'b000,-1,0,0,0,0, 0,0);
        add(1,0,0,1,32'hC2,0,0, 1,3'b000,-1,0,0,0,0, 0,0);
        add(1,0,0,3,32'hC3,0,0, 1,3'b000,-1,0,0,0,0, 0,0);
        add(1,0,1,0,32'hC4,0,0, 1,3'b000,-1,0,0,0,0, 0,1);
        add(1,1,1,3,32'hC5,0,0, 1,3'b000,-1,0,0,0,0, 0,2);
        // 4: framing errors
        add(1,0,0,0,32'hD0,0,7, 1,3'b000,-1,0,0,0,0, 1,2);
        add(0,0,0,0,32'h0 ,0,7, 1,3'b000,-1,0,0,0,0, 0,2);
        add(1,1,0,1,32'hE0,0,7, 1,3'b010, 1,32'hE0,1,0,0, 0,2);
        add(1,0,0,1,32'hE1,0,7, 1,3'b010, 1,32'hE1,0,0,0, 0,2);
        add(1,1,0,2,32'hF0,0,7, 1,3'b100, 2,32'hF0,1,0,0, 1,2);
        add(1,0,0,1,32'hF1,0,7, 1,3'b100, 2,32'hF1,0,0,0, 0,2);
        add(1,0,1,1,32'hF2,0,7, 1,3'b100, 2,32'hF2,0,1,0, 0,2);
        // 5: in_channel ignored after SOP
        add(1,1,0,1,32'h60,0,7, 1,3'b010, 1,32'h60,1,0,0, 0,2);
        add(1,0,0,0,32'h61,0,7, 1,3'b010, 1,32'h61,0,0,0, 0,2);
        add(1,0,0,0,32'h62,0,7, 1,3'b010, 1,32'h62,0,0,0, 0,2);
        add(1,0,1,1,32'h63,1,7, 1,3'b010, 1,32'h63,0,1,1, 0,2);
        // stalled port2 does not block port1
        add(1,1,1,2,32'h70,0,3, 1,3'b100, 2,32'h70,1,1,0, 0,2);
        add(1,1,0,1,32'h71,0,3, 1,3'b110, 1,32'h71,1,0,0, 0,2);
        add(1,0,1,1,32'h72,2,3, 1,3'b110, 1,32'h72,0,1,2, 0,2);
        add(0,0,0,0,32'h0 ,0,7, 1,3'b000,-1,0,0,0,0, 0,2);
        // SOP inside a dropped packet restarts without counting the drop
        add(1,1,0,3,32'h80,0,7, 1,3'b000,-1,0,0,0,0, 0,2);
        add(1,1,0,0,32'h81,0,7, 1,3'b001, 0,32'h81,1,0,0, 1,2);
        add(1,0,1,2,32'h82,3,7, 1,3'b001, 0,32'h82,0,1,3, 0,2);
        add(0,0,0,0,32'h0 ,0,7, 1,3'b000,-1,0,0,0,0, 0,2);

        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data", out_data[31:0] | out_data[63:32] | out_data[95:64], 0);
        chk("reset out_sop_eop_empty", 32'(out_startofpacket | out_endofpacket) | 32'(out_empty), 0);
        chk("reset drop_count", 32'(drop_count), 0);
        chk("reset sop_error", 32'(sop_error), 0);
        chk("reset in_ready", 32'(in_ready), 1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].v, vecs[k].sop, vecs[k].eop, vecs[k].ch, vecs[k].d,
                  vecs[k].emp, vecs[k].ordy);
            #1;
            chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].e_irdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
            chk($sformatf("v%0d sop_error", k), 32'(sop_error), 32'(vecs[k].e_serr));
            chk($sformatf("v%0d drop_count", k), 32'(drop_count), 32'(vecs[k].e_drop));
            if (vecs[k].port >= 0) begin
                chk($sformatf("v%0d out_data", k), out_data[vecs[k].port*DW +: DW], vecs[k].e_d);
                chk($sformatf("v%0d out_sop", k), 32'(out_startofpacket[vecs[k].port]), 32'(vecs[k].e_sop));
                chk($sformatf("v%0d out_eop", k), 32'(out_endofpacket[vecs[k].port]), 32'(vecs[k].e_eop));
                chk($sformatf("v%0d out_empty", k), 32'(out_empty[vecs[k].port*EW +: EW]), 32'(vecs[k].e_emp));
            end
        end

        // drop_count saturation
        do_reset();
        #1;
        chk("sat start", 32'(drop_count), 0);
        for (int k = 0; k < 65535; k++) begin
            @(negedge clk);
            drive(1, 1, 1, 3, 32'(k), 0, 3'b111);
            @(posedge clk);
        end
        #1;
        chk("sat reach FFFF", 32'(drop_count), 32'hFFFF);
        @(negedge clk);
        drive(1, 1, 1, 3, 32'h5A, 0, 3'b111);
        @(posedge clk);
        #1;
        chk("sat hold FFFF", 32'(drop_count), 32'hFFFF);
        chk("sat out_valid", 32'(out_valid), 0);

        // async reset mid-packet on ch2
        @(negedge clk);
        drive(1, 1, 0, 2, 32'h90, 0, 3'b111);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 2, 32'h91, 0, 3'b111);
        @(posedge clk);
        #1;
        chk("mid-pkt out_valid", 32'(out_valid), 32'b100);
        chk("mid-pkt out_data", out_data[2*DW +: DW], 32'h91);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3'b111);
        reset_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async out_data", out_data[2*DW +: DW], 0);
        chk("async drop_count", 32'(drop_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(1, 0, 1, 2, 32'h92, 0, 3'b111);
        @(posedge clk);
        #1;
        chk("post-reset sop_error", 32'(sop_error), 1);
        chk("post-reset discarded", 32'(out_valid), 0);
        @(negedge clk);
        drive(1, 1, 1, 0, 32'h93, 1, 3'b111);
        #1;
        chk("post-reset in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("post-reset ch0 valid", 32'(out_valid), 32'b001);
        chk("post-reset ch0 data", out_data[0 +: DW], 32'h93);
        chk("post-reset ch0 sop_eop", {30'd0, out_startofpacket[0], out_endofpacket[0]}, 32'b11);
        chk("post-reset sop_error clr", 32'(sop_error), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3'b111);
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
